// File: rtl/pair_exit_queue.sv
// Frame-slotted FIFO. The leading slots of each frame accept writes, the next
// RD_PER_FRAME slots pop one record each (or emit a sentinel when empty).
module pair_exit_queue #(
  parameter int DATA_W       = 227,
  parameter int DEPTH        = 64,
  parameter int FRAME_LEN    = 16,
  parameter int WR_SLOTS     = 14,
  parameter int RD_PER_FRAME = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  output logic                       out_empty,
  output logic                       frame_start,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                drop_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  // One extra bit so WR_SLOTS+RD_PER_FRAME (which may equal FRAME_LEN) fits.
  localparam int SLOT_W = $clog2(FRAME_LEN + 1);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME_LEN - 1);
  localparam logic [SLOT_W-1:0] WR_END    = SLOT_W'(WR_SLOTS);
  localparam logic [SLOT_W-1:0] RD_END    = SLOT_W'(WR_SLOTS + RD_PER_FRAME);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [DATA_W-1:0] SENTINEL  = {1'b1, {(DATA_W-1){1'b0}}};

  logic [SLOT_W-1:0] slot;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic is_write;
  logic is_read;
  logic full;
  logic empty;
  logic do_write;
  logic do_pop;
  logic do_drop;

  always_comb begin
    is_write = (slot < WR_END);
    is_read  = (slot >= WR_END) && (slot < RD_END);
    full     = (level == LVL_FULL);
    empty    = (level == '0);
    // A flush discards any coincident write or pop; neither counts as a drop.
    do_write = is_write && in_valid && !full && !flush;
    do_drop  = is_write && in_valid &&  full && !flush;
    do_pop   = is_read && !empty && !flush;
  end

  assign frame_start = (slot == '0);

  // Storage carries no reset; level/pointers guarantee stale entries are never read.
  always_ff @(posedge clk) begin
    if (!reset && do_write) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      drop_count <= '0;
      out_valid  <= 1'b0;
      out_empty  <= 1'b1;
      out_data   <= SENTINEL;
    end else begin
      slot      <= (slot == SLOT_LAST) ? '0 : slot + SLOT_W'(1);
      out_valid <= is_read;

      if (do_drop && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end

      // Write and read slots are disjoint, so at most one of these fires.
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else if (do_write) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        level  <= level + LVL_W'(1);
      end else if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        level  <= level - LVL_W'(1);
      end

      if (is_read) begin
        if (do_pop) begin
          out_data  <= mem[rd_ptr];
          out_empty <= 1'b0;
        end else begin
          out_data  <= SENTINEL;
          out_empty <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/pair_exit_queue.md
PAIR_EXIT_QUEUE -- requirements
Module: pair_exit_queue

Interface
REQ-001 The block SHALL have parameter DATA_W, default 227, payload width including MSB sentinel bit.
REQ-002 The block SHALL have parameter DEPTH, default 64, queue capacity in entries, power of two, at least 2.
REQ-003 The block SHALL have parameter FRAME_LEN, default 16, cycles per frame, at most 256.
REQ-004 The block SHALL have parameter WR_SLOTS, default 14, count of leading frame slots that accept writes, 1 to FRAME_LEN-1.
REQ-005 The block SHALL have parameter RD_PER_FRAME, default 1, pops per frame, 1 to FRAME_LEN-WR_SLOTS.
REQ-006 The block SHALL have port clk, input, 1 bit, the clock.
REQ-007 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-008 The block SHALL have port flush, input, 1 bit, a synchronous queue clear.
REQ-009 The block SHALL have port in_valid, input, 1 bit, which qualifies in_data.
REQ-010 The block SHALL have port in_data, input, DATA_W bits, the pair record.
REQ-011 The block SHALL have port out_data, output, DATA_W bits, the popped record or the sentinel.
REQ-012 The block SHALL have port out_valid, output, 1 bit, a one-cycle pulse per read slot.
REQ-013 The block SHALL have port out_empty, output, 1 bit, asserted when the last read slot found the queue empty.
REQ-014 The block SHALL have port frame_start, output, 1 bit, high while slot is 0.
REQ-015 The block SHALL have port level, output, clog2(DEPTH)+1 bits, the current occupancy.
REQ-016 The block SHALL have port drop_count, output, 16 bits, a saturating count of rejected writes.

Function
REQ-017 The slot counter SHALL run 0 to FRAME_LEN-1, then wrap to 0.
REQ-018 A write slot is a slot below WR_SLOTS; a read slot is a slot from WR_SLOTS to WR_SLOTS+RD_PER_FRAME-1; any remaining slots SHALL be idle.
REQ-019 When a write slot has in_valid=1 and level<DEPTH, in_data SHALL be enqueued and level SHALL increment.
REQ-020 When a write slot has in_valid=1 and level==DEPTH, the record SHALL be dropped and drop_count SHALL increment, saturating at 0xFFFF.
REQ-021 in_valid outside write slots SHALL be ignored, and drop_count SHALL NOT increment.
REQ-022 Every read slot SHALL pulse out_valid=1 on the following cycle, for a latency of 1 cycle.
REQ-023 On a read slot with level>0, the head entry SHALL be popped; out_data SHALL become that entry, out_empty SHALL become 0, and level SHALL decrement.
REQ-024 On a read slot with level==0, out_data SHALL become the sentinel (MSB=1, all other bits 0) and out_empty SHALL become 1.
REQ-025 out_data and out_empty SHALL hold their values between read slots.
REQ-026 Ordering SHALL be strict FIFO, and pointers SHALL wrap modulo DEPTH.
REQ-027 Storage SHALL be an inferred register or RAM array with no vendor IP.
REQ-028 flush=1 SHALL set the pointers and level to 0 on the next edge.
REQ-029 flush SHALL NOT alter the slot counter, drop_count, out_data or out_empty.
REQ-030 A write coinciding with flush SHALL be discarded without counting as a drop.
REQ-031 A pop coinciding with flush SHALL output the sentinel with out_empty=1.
REQ-032 Write and pop slots are disjoint by construction, so level SHALL change by at most 1 per cycle.

Reset
REQ-033 Reset SHALL set slot=0, pointers=0, level=0, drop_count=0, out_valid=0, out_empty=1, and out_data to the sentinel.
REQ-034 Reset SHALL take priority over flush and all inputs, including mid-frame, and the frame SHALL restart at slot 0 on the next cycle.
REQ-035 Queue contents need no reset, but stale entries SHALL never be output.

Verification
REQ-036 Scenario: defaults with no writes for 3 frames -> out_valid pulses at cycles 15, 31 and 47 after reset release, each with out_data=sentinel and out_empty=1.
REQ-037 Scenario: writes of 0x1, 0x2 and 0x3 in slots 0 to 2 of frame 0 -> pops of 0x1, 0x2 and 0x3 in frames 0, 1 and 2, then the sentinel in frame 3.
REQ-038 Scenario: DEPTH=4 with 14 valid writes in one frame -> level=4, drop_count=10, and the first 4 records pop in order.
REQ-039 Scenario: in_valid held high during slots 14 and 15 -> no enqueue and drop_count unchanged.
REQ-040 Scenario: flush at slot 5 with level=3 -> level=0 next cycle and the read slot of that frame outputs the sentinel.
REQ-041 Scenario: reset at slot 9 with level=5 -> level=0, drop_count=0, frame_start=1 on the first cycle after release.
